// File: rtl/regfile_seq.sv
// Register file sequencer: hazard-checked operand fetch plus writeback replay.
// Optional define REGFILE_SEQ_BYPASS_EN lets a RAW-blocked issue go during the write cycle.
module regfile_seq #(
    parameter int DW   = 8,
    parameter int NREG = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          IssueValid,
    output logic          IssueReady,
    input  logic [1:0]    IssueSrcA,
    input  logic [1:0]    IssueSrcB,
    input  logic [1:0]    IssueDst,
    input  logic          IssueHasDst,
    output logic          OpValid,
    input  logic          OpReady,
    output logic [DW-1:0] OpA,
    output logic [DW-1:0] OpB,
    output logic [1:0]    OpDst,
    output logic          OpHasDst,
    input  logic          WbValid,
    output logic          WbReady,
    input  logic [1:0]    WbReg,
    input  logic [DW-1:0] WbData,
    output logic [1:0]    RfReadRegA,
    output logic [1:0]    RfReadRegB,
    input  logic [DW-1:0] RfReadDataA,
    input  logic [DW-1:0] RfReadDataB,
    output logic [1:0]    RfWriteReg,
    output logic [DW-1:0] RfWriteData,
    output logic          RfWriteEnable
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_READ,
        S_OUT
    } state_t;

    state_t          r_state;
    state_t          w_next;
    logic [NREG-1:0] r_busy;
    logic [NREG-1:0] w_busy_next;
    logic [1:0]      r_src_a;
    logic [1:0]      r_src_b;
    logic [1:0]      r_dst;
    logic            r_has_dst;
    logic            r_retry;
    logic [DW-1:0]   r_op_a;
    logic [DW-1:0]   r_op_b;
    logic            r_we;
    logic [1:0]      r_wreg;
    logic [DW-1:0]   r_wdata;

    logic w_busy_a;
    logic w_busy_b;
    logic w_busy_d;
    logic w_hazard;
    logic w_accept;
    logic w_collide;
    logic w_repeat;

    // A source being written this cycle is free once the edge lands
`ifdef REGFILE_SEQ_BYPASS_EN
    assign w_busy_a = r_busy[IssueSrcA] & ~(r_we & (r_wreg == IssueSrcA));
    assign w_busy_b = r_busy[IssueSrcB] & ~(r_we & (r_wreg == IssueSrcB));
`else
    assign w_busy_a = r_busy[IssueSrcA];
    assign w_busy_b = r_busy[IssueSrcB];
`endif
    assign w_busy_d = IssueHasDst & r_busy[IssueDst];
    assign w_hazard = w_busy_a | w_busy_b | w_busy_d;

    assign IssueReady = (r_state == S_IDLE) & ~w_hazard & ~rst;
    assign w_accept   = IssueValid & IssueReady;
    assign WbReady    = ~rst;

    // Write landing on a source during READ makes the sample stale
    assign w_collide = r_we & ((r_wreg == r_src_a) | (r_wreg == r_src_b));
    assign w_repeat  = w_collide & ~r_retry;

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE: if (w_accept) w_next = S_READ;
            S_READ: if (!w_repeat) w_next = S_OUT;
            S_OUT:  if (OpReady) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Clear then set, so a same-edge set of one bit wins
    always_comb begin
        w_busy_next = r_busy;
        if (r_we) w_busy_next[r_wreg] = 1'b0;
        if (w_accept && IssueHasDst) w_busy_next[IssueDst] = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_busy  <= '0;
        end else begin
            r_state <= w_next;
            r_busy  <= w_busy_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_src_a   <= '0;
            r_src_b   <= '0;
            r_dst     <= '0;
            r_has_dst <= 1'b0;
        end else if (w_accept) begin
            r_src_a   <= IssueSrcA;
            r_src_b   <= IssueSrcB;
            r_dst     <= IssueDst;
            r_has_dst <= IssueHasDst;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_op_a  <= '0;
            r_op_b  <= '0;
            r_retry <= 1'b0;
        end else if (r_state == S_READ) begin
            if (w_repeat) begin
                r_retry <= 1'b1;
            end else begin
                r_op_a  <= RfReadDataA;
                r_op_b  <= RfReadDataB;
                r_retry <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_we    <= 1'b0;
            r_wreg  <= '0;
            r_wdata <= '0;
        end else if (WbValid) begin
            r_we    <= 1'b1;
            r_wreg  <= WbReg;
            r_wdata <= WbData;
        end else begin
            r_we    <= 1'b0;
        end
    end

    assign OpValid       = (r_state == S_OUT);
    assign OpA           = r_op_a;
    assign OpB           = r_op_b;
    assign OpDst         = r_dst;
    assign OpHasDst      = r_has_dst;
    assign RfReadRegA    = r_src_a;
    assign RfReadRegB    = r_src_b;
    assign RfWriteReg    = r_wreg;
    assign RfWriteData   = r_wdata;
    assign RfWriteEnable = r_we;

endmodule

// File: tb/tb_regfile_seq.sv
// Directed bench for regfile_seq with a behavioural 4x8 register file.
module tb_regfile_seq;

    logic       clk = 1'b0;
    logic       rst;
    logic       IssueValid;
    logic       IssueReady;
    logic [1:0] IssueSrcA;
    logic [1:0] IssueSrcB;
    logic [1:0] IssueDst;
    logic       IssueHasDst;
    logic       OpValid;
    logic       OpReady;
    logic [7:0] OpA;
    logic [7:0] OpB;
    logic [1:0] OpDst;
    logic       OpHasDst;
    logic       WbValid;
    logic       WbReady;
    logic [1:0] WbReg;
    logic [7:0] WbData;
    logic [1:0] RfReadRegA;
    logic [1:0] RfReadRegB;
    logic [7:0] RfReadDataA;
    logic [7:0] RfReadDataB;
    logic [1:0] RfWriteReg;
    logic [7:0] RfWriteData;
    logic       RfWriteEnable;

    logic [7:0] rf [4];
    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    always @(posedge clk)
        if (RfWriteEnable) rf[RfWriteReg] <= RfWriteData;

    assign RfReadDataA = rf[RfReadRegA];
    assign RfReadDataB = rf[RfReadRegB];

    regfile_seq #(.DW(8), .NREG(4)) dut (
        .clk(clk), .rst(rst),
        .IssueValid(IssueValid), .IssueReady(IssueReady),
        .IssueSrcA(IssueSrcA), .IssueSrcB(IssueSrcB),
        .IssueDst(IssueDst), .IssueHasDst(IssueHasDst),
        .OpValid(OpValid), .OpReady(OpReady),
        .OpA(OpA), .OpB(OpB), .OpDst(OpDst), .OpHasDst(OpHasDst),
        .WbValid(WbValid), .WbReady(WbReady),
        .WbReg(WbReg), .WbData(WbData),
        .RfReadRegA(RfReadRegA), .RfReadRegB(RfReadRegB),
        .RfReadDataA(RfReadDataA), .RfReadDataB(RfReadDataB),
        .RfWriteReg(RfWriteReg), .RfWriteData(RfWriteData),
        .RfWriteEnable(RfWriteEnable)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge
    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic issue(input logic [1:0] a, input logic [1:0] b,
                         input logic [1:0] d, input logic hd);
        IssueValid  = 1'b1;
        IssueSrcA   = a;
        IssueSrcB   = b;
        IssueDst    = d;
        IssueHasDst = hd;
    endtask

    initial begin
        for (int i = 0; i < 4; i++) rf[i] = 8'h00;
        rst = 1'b1;
        IssueValid = 0; IssueSrcA = 0; IssueSrcB = 0;
        IssueDst = 0; IssueHasDst = 0; OpReady = 0;
        WbValid = 0; WbReg = 0; WbData = 0;

        // Reset state
        repeat (3) cyc();
        #1;
        chk("rst_opvalid", OpValid, 0);
        chk("rst_opa", OpA, 0);
        chk("rst_opb", OpB, 0);
        chk("rst_opdst", {OpHasDst, OpDst}, 0);
        chk("rst_rdregs", {RfReadRegA, RfReadRegB}, 0);
        chk("rst_wr", {RfWriteEnable, RfWriteReg, RfWriteData}, 0);
        chk("rst_issueready", IssueReady, 0);
        chk("rst_wbready", WbReady, 0);
        rst = 1'b0;
        #1;
        chk("idle_issueready", IssueReady, 1);
        chk("idle_wbready", WbReady, 1);

        // Back-to-back writebacks
        WbValid = 1; WbReg = 0; WbData = 8'hAA;
        cyc();
        WbReg = 1; WbData = 8'h55;
        #1;
        chk("wb0", {RfWriteEnable, RfWriteReg, RfWriteData}, {1'b1, 2'd0, 8'hAA});
        cyc();
        WbValid = 0;
        #1;
        chk("wb1", {RfWriteEnable, RfWriteReg, RfWriteData}, {1'b1, 2'd1, 8'h55});
        cyc();
        #1;
        chk("wb_done", RfWriteEnable, 0);

        // Plain read with OUT stall
        issue(0, 1, 0, 0);
        chk("rd_ready", IssueReady, 1);
        cyc();
        IssueValid = 0;
        #1;
        chk("rd_read_state", OpValid, 0);
        cyc();
        #1;
        for (int i = 0; i < 5; i++) begin
            chk("rd_hold_valid", OpValid, 1);
            chk("rd_hold_ab", {OpA, OpB}, {8'hAA, 8'h55});
            chk("rd_hold_noissue", IssueReady, 0);
            if (i < 4) cyc();
        end
        OpReady = 1;
        cyc();
        OpReady = 0;
        #1;
        chk("rd_done", {OpValid, IssueReady}, 2'b01);

        // RAW on R2
        issue(0, 0, 2, 1);
        cyc();
        issue(2, 0, 0, 0);
        OpReady = 1;
        cyc();
        #1;
        chk("raw_prod_out", {OpValid, OpHasDst, OpDst}, {1'b1, 1'b1, 2'd2});
        cyc();
        OpReady = 0;
        #1;
        chk("raw_blocked0", IssueReady, 0);
        cyc();
        WbValid = 1; WbReg = 2; WbData = 8'h3C;
        #1;
        chk("raw_blocked1", IssueReady, 0);
        cyc();
        WbValid = 0;
        #1;
`ifdef REGFILE_SEQ_BYPASS_EN
        chk("raw_write_cycle", IssueReady, 1);
        cyc();
        IssueValid = 0;
        #1;
        chk("raw_read_state", OpValid, 0);
        cyc();
`else
        chk("raw_write_cycle", IssueReady, 0);
        cyc();
        #1;
        chk("raw_after_write", IssueReady, 1);
        cyc();
        IssueValid = 0;
        cyc();
`endif
        #1;
        chk("raw_opvalid", OpValid, 1);
        chk("raw_ab", {OpA, OpB}, {8'h3C, 8'hAA});
        OpReady = 1;
        cyc();

        // WAW on R2
        issue(0, 0, 2, 1);
        #1;
        chk("waw_first_ready", IssueReady, 1);
        cyc();
        cyc();
        cyc();
        #1;
        chk("waw_blocked", IssueReady, 0);
        WbValid = 1; WbReg = 2; WbData = 8'h77;
        cyc();
        WbValid = 0;
        #1;
        chk("waw_write_cycle", IssueReady, 0);
        cyc();
        #1;
        chk("waw_after_write", IssueReady, 1);
        cyc();
        issue(2, 0, 0, 0);
        cyc();
        cyc();
        #1;
        chk("waw_busy_reset", IssueReady, 0);
        IssueValid = 0;
        WbValid = 1; WbReg = 2; WbData = 8'h77;
        cyc();
        WbValid = 0;
        cyc();
        #1;
        chk("waw_cleared", IssueReady, 1);
        OpReady = 0;

        // READ collision
        WbValid = 1; WbReg = 3; WbData = 8'h11;
        cyc();
        WbValid = 0;
        cyc();
        issue(3, 0, 2, 1);
        WbValid = 1; WbReg = 3; WbData = 8'h99;
        #1;
        chk("col_ready", IssueReady, 1);
        cyc();
        IssueValid = 0;
        WbValid = 0;
        #1;
        chk("col_read1", {OpValid, RfWriteEnable}, 2'b01);
        cyc();
        #1;
        chk("col_read2", OpValid, 0);
        cyc();
        #1;
        chk("col_opvalid", OpValid, 1);
        chk("col_ab", {OpA, OpB}, {8'h99, 8'hAA});
        chk("col_dst", {OpHasDst, OpDst}, {1'b1, 2'd2});

        // Reset mid-op with a pending write
        WbValid = 1; WbReg = 1; WbData = 8'h42;
        cyc();
        WbValid = 0;
        #1;
        chk("mid_pre", {OpValid, RfWriteEnable}, 2'b11);
        rst = 1'b1;
        #1;
        chk("mid_async", {OpValid, RfWriteEnable}, 2'b00);
        chk("mid_opa", OpA, 0);
        chk("mid_ready", {IssueReady, WbReady}, 2'b00);
        cyc();
        rst = 1'b0;
        issue(2, 1, 0, 0);
        #1;
        chk("mid_busy_clear", IssueReady, 1);
        cyc();
        IssueValid = 0;
        cyc();
        #1;
        chk("mid_opvalid", OpValid, 1);
        chk("mid_ab", {OpA, OpB}, {8'h77, 8'h55});
        OpReady = 1;
        cyc();
        OpReady = 0;
        #1;
        chk("mid_end", {OpValid, IssueReady}, 2'b01);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
